// File: rtl/psum_requant.sv
// Partial-sum collector and requantiser: adds a per-pixel bias to K_LEN saturated MAC
// partial sums, then applies ReLU, round-and-shift and 8-bit clipping behind a one-entry output register.
module psum_requant #(
   parameter int I_PSUM = 16,
   parameter int ACC_W  = 24,
   parameter int O_W    = 8,
   parameter int K_LEN  = 9,
   parameter int SHIFT  = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [I_PSUM-1:0] i_psum,
   input  logic [I_PSUM-1:0] i_bias,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [O_W-1:0]    o_data,
   output logic              o_sat,
   output logic [7:0]        o_cnt
);

   localparam int SUM_W = ACC_W + 1;
   localparam int RND_W = ACC_W + 1;

   localparam logic [7:0]       LAST_CNT  = 8'(K_LEN - 1);
   localparam logic [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [RND_W-1:0] HALF      = RND_W'(1) << (SHIFT - 1);
   localparam logic [O_W-1:0]   OUT_MAX   = {1'b0, {(O_W-1){1'b1}}};
   localparam logic [RND_W-1:0] OUT_MAX_W = {{(RND_W-O_W+1){1'b0}}, {(O_W-1){1'b1}}};

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic [O_W-1:0]   data_q, data_d;
   logic             sat_q, sat_d;

   logic             accept;
   logic             last;
   logic             finalise;
   logic [SUM_W-1:0] base_ext;
   logic [SUM_W-1:0] psum_ext;
   logic [SUM_W-1:0] sum_wide;
   logic [ACC_W-1:0] sum_sat;
   logic [RND_W-1:0] rnd_wide;
   logic             rnd_sat;
   logic [O_W-1:0]   rnd_data;

   // Only the closing partial sum can stall: it is the one that needs the output register free.
   always_comb begin
      last     = (cnt_q == LAST_CNT);
      o_ready  = !last || !valid_q || i_ready;
      accept   = i_valid && o_ready;
      finalise = accept && last;
   end

   // The first partial sum of a pixel starts from the bias instead of the running total.
   // One guard bit is enough to see overflow; disagreeing top bits select the clamp direction.
   always_comb begin
      psum_ext = {{(SUM_W-I_PSUM){i_psum[I_PSUM-1]}}, i_psum};
      if (cnt_q == 8'd0) begin
         base_ext = {{(SUM_W-I_PSUM){i_bias[I_PSUM-1]}}, i_bias};
      end else begin
         base_ext = {acc_q[ACC_W-1], acc_q};
      end
      sum_wide = base_ext + psum_ext;
      if (sum_wide[SUM_W-1] != sum_wide[SUM_W-2]) begin
         sum_sat = sum_wide[SUM_W-1] ? ACC_MIN : ACC_MAX;
      end else begin
         sum_sat = sum_wide[ACC_W-1:0];
      end
   end

   // ReLU first, so the rounding add only ever sees a positive value and cannot wrap.
   always_comb begin
      if (sum_sat[ACC_W-1] || (sum_sat == '0)) begin
         rnd_wide = '0;
      end else begin
         rnd_wide = ({1'b0, sum_sat} + HALF) >> SHIFT;
      end
      rnd_sat  = (rnd_wide > OUT_MAX_W);
      rnd_data = rnd_sat ? OUT_MAX : rnd_wide[O_W-1:0];
   end

   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      data_d  = data_q;
      sat_d   = sat_q;
      if (accept) begin
         acc_d = sum_sat;
         cnt_d = last ? 8'd0 : cnt_q + 8'd1;
      end
      // A new result replacing a draining one keeps o_valid high for back-to-back throughput.
      if (finalise) begin
         valid_d = 1'b1;
         data_d  = rnd_data;
         sat_d   = rnd_sat;
      end else if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         sat_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         sat_q   <= sat_d;
      end
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;
   assign o_sat   = sat_q;
   assign o_cnt   = cnt_q;

endmodule

// File: tb/tb_psum_requant.sv
// Bench for psum_requant: a default instance and a narrow-accumulator (ACC_W=17) instance,
// each with its own reference model and expected-result queue.
module tb_psum_requant;

   localparam int K = 9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        valid_a, ready_in_a, ready_a, out_valid_a, sat_a;
   logic [15:0] psum_a, bias_a;
   logic [7:0]  data_a, cnt_a;
   logic        valid_b, ready_in_b, ready_b, out_valid_b, sat_b;
   logic [15:0] psum_b, bias_b;
   logic [7:0]  data_b, cnt_b;

   psum_requant dut_a (
      .i_clk(clk), .i_rst(rst), .i_valid(valid_a), .o_ready(ready_a),
      .i_psum(psum_a), .i_bias(bias_a), .o_valid(out_valid_a), .i_ready(ready_in_a),
      .o_data(data_a), .o_sat(sat_a), .o_cnt(cnt_a)
   );

   psum_requant #(.ACC_W(17)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_valid(valid_b), .o_ready(ready_b),
      .i_psum(psum_b), .i_bias(bias_b), .o_valid(out_valid_b), .i_ready(ready_in_b),
      .o_data(data_b), .o_sat(sat_b), .o_cnt(cnt_b)
   );

   int     checks = 0;
   int     errors = 0;
   int     exp_q_a[$];
   int     exp_q_b[$];
   longint acc_m[2];
   int     cnt_m[2];
   int     acc_w[2] = '{24, 17};
   int     e_a, e_b;

   task automatic checkOutput(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint satAcc(input longint v, input int w);
      longint hi = (longint'(1) << (w - 1)) - 1;
      longint lo = -(longint'(1) << (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // Expected result packed as sat*256 + data.
   function automatic int requant(input longint s);
      longint r, d, st;
      r  = (s <= 0) ? 0 : ((s + 8) >>> 4);
      d  = (r > 127) ? 127 : r;
      st = (r > 127) ? 1 : 0;
      return int'(st * 256 + d);
   endfunction

   task automatic modelAccept(input int sel, input logic signed [15:0] bias, input logic signed [15:0] psum);
      longint base;
      base = (cnt_m[sel] == 0) ? longint'(bias) : acc_m[sel];
      acc_m[sel] = satAcc(base + longint'(psum), acc_w[sel]);
      if (cnt_m[sel] == K - 1) begin
         cnt_m[sel] = 0;
         if (sel == 0) exp_q_a.push_back(requant(acc_m[sel]));
         else          exp_q_b.push_back(requant(acc_m[sel]));
      end else begin
         cnt_m[sel]++;
      end
   endtask

   // Offers one partial sum and holds it until accepted; returns 1 time unit after the accepting edge.
   task automatic applyStimulus(input int sel, input logic [15:0] bias, input logic [15:0] psum);
      int   budget = 0;
      logic rdy;
      if (sel == 0) begin valid_a = 1'b1; bias_a = bias; psum_a = psum; end
      else          begin valid_b = 1'b1; bias_b = bias; psum_b = psum; end
      @(negedge clk);
      rdy = (sel == 0) ? ready_a : ready_b;
      while (!rdy && budget < 40) begin
         budget++;
         @(negedge clk);
         rdy = (sel == 0) ? ready_a : ready_b;
      end
      if (!rdy) checkOutput("accept_timeout", 0, 1);
      else      modelAccept(sel, $signed(bias), $signed(psum));
      @(posedge clk);
      #1;
      if (sel == 0) valid_a = 1'b0;
      else          valid_b = 1'b0;
   endtask

   task automatic runPixel(input int sel, input logic [15:0] bias, input logic [15:0] psum);
      for (int i = 0; i < K; i++) begin
         applyStimulus(sel, (i == 0) ? bias : 16'($urandom), psum);
      end
   endtask

   // Scoreboard: every output handshake consumes the oldest expected result.
   always @(negedge clk) begin
      if (!rst && out_valid_a && ready_in_a) begin
         if (exp_q_a.size() == 0) begin
            checkOutput("sb_a_unexpected", 1, 0);
         end else begin
            e_a = exp_q_a.pop_front();
            checkOutput("sb_a_data", longint'(data_a), longint'(e_a % 256));
            checkOutput("sb_a_sat", longint'(sat_a), longint'(e_a / 256));
         end
      end
      if (!rst && out_valid_b && ready_in_b) begin
         if (exp_q_b.size() == 0) begin
            checkOutput("sb_b_unexpected", 1, 0);
         end else begin
            e_b = exp_q_b.pop_front();
            checkOutput("sb_b_data", longint'(data_b), longint'(e_b % 256));
            checkOutput("sb_b_sat", longint'(sat_b), longint'(e_b / 256));
         end
      end
   end

   initial begin
      rst = 1'b1;
      valid_a = 1'b0; ready_in_a = 1'b1; psum_a = '0; bias_a = '0;
      valid_b = 1'b0; ready_in_b = 1'b1; psum_b = '0; bias_b = '0;
      acc_m = '{0, 0};
      cnt_m = '{0, 0};
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_cnt", longint'(cnt_a), 0);
      checkOutput("rst_valid", longint'(out_valid_a), 0);
      checkOutput("rst_data", longint'(data_a), 0);
      checkOutput("rst_sat", longint'(sat_a), 0);
      checkOutput("rst_ready", longint'(ready_a), 1);
      @(posedge clk);
      #1 rst = 1'b0;

      $display("[TB] basic pixel");
      runPixel(0, 16'd0, 16'd50);
      checkOutput("p1_valid", longint'(out_valid_a), 1);
      checkOutput("p1_data", longint'(data_a), 28);
      checkOutput("p1_sat", longint'(sat_a), 0);
      checkOutput("p1_cnt", longint'(cnt_a), 0);
      @(posedge clk);
      #1 checkOutput("p1_pulse", longint'(out_valid_a), 0);

      runPixel(0, -16'sd100, 16'd50);
      checkOutput("bias_data", longint'(data_a), 22);
      runPixel(0, 16'd0, -16'sd50);
      checkOutput("relu_data", longint'(data_a), 0);
      checkOutput("relu_sat", longint'(sat_a), 0);
      runPixel(0, 16'd0, 16'sd32767);
      checkOutput("clip_data", longint'(data_a), 127);
      checkOutput("clip_sat", longint'(sat_a), 1);

      $display("[TB] backpressure");
      runPixel(0, 16'd0, 16'd50);
      ready_in_a = 1'b0;
      for (int i = 0; i < K - 1; i++) applyStimulus(0, (i == 0) ? 16'd10 : 16'($urandom), 16'd50);
      checkOutput("bp_cnt", longint'(cnt_a), 8);
      valid_a = 1'b1; bias_a = 16'($urandom); psum_a = 16'd50;
      repeat (2) begin
         @(negedge clk);
         checkOutput("bp_ready", longint'(ready_a), 0);
         checkOutput("bp_hold_valid", longint'(out_valid_a), 1);
         checkOutput("bp_hold_data", longint'(data_a), 28);
      end
      @(posedge clk);
      #1 ready_in_a = 1'b1;
      applyStimulus(0, bias_a, 16'd50);
      checkOutput("bp_b2b_valid", longint'(out_valid_a), 1);
      checkOutput("bp_b2b_data", longint'(data_a), 29);
      @(posedge clk);
      #1 checkOutput("bp_drained", longint'(out_valid_a), 0);

      $display("[TB] reset mid-pixel");
      for (int i = 0; i < 5; i++) applyStimulus(0, 16'd7, 16'd50);
      checkOutput("mid_cnt", longint'(cnt_a), 5);
      rst = 1'b1;
      acc_m = '{0, 0};
      cnt_m = '{0, 0};
      @(posedge clk);
      #1;
      checkOutput("mid_rst_cnt", longint'(cnt_a), 0);
      checkOutput("mid_rst_valid", longint'(out_valid_a), 0);
      checkOutput("mid_rst_data", longint'(data_a), 0);
      rst = 1'b0;
      runPixel(0, 16'd0, 16'd50);
      checkOutput("post_rst_data", longint'(data_a), 28);

      $display("[TB] narrow accumulator");
      runPixel(1, 16'd0, 16'sd32767);
      checkOutput("acc17_data", longint'(data_b), 127);
      checkOutput("acc17_sat", longint'(sat_b), 1);
      runPixel(1, -16'sd32768, -16'sd32768);
      checkOutput("acc17_neg_data", longint'(data_b), 0);
      runPixel(1, 16'd0, 16'd50);
      checkOutput("acc17_small", longint'(data_b), 28);

      repeat (3) @(negedge clk);
      checkOutput("sb_a_left", longint'(exp_q_a.size()), 0);
      checkOutput("sb_b_left", longint'(exp_q_b.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
